// File: rtl/mac_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mac_chain_ctrl
// Description : Job controller for a cascade of CHAIN_LEN MAC PEs. It accepts
//               cfg_len feature beats, skews a per-stage pulse down the chain
//               and tracks results until the last one leaves the final stage.
//               Optional abort input enabled by macro MAC_CHAIN_CTRL_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_chain_ctrl #(
    parameter int CHAIN_LEN = 9,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 DSP_clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] cfg_len,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [CHAIN_LEN-1:0] pe_pulse,
    output logic                 out_valid,
    output logic                 done
`ifdef MAC_CHAIN_CTRL_ABORT_EN
    ,
    input  logic                 abort
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_busy;
    logic                   r_done;
    logic [CNT_WIDTH-1:0]   r_len;
    logic [CNT_WIDTH-1:0]   r_acc_cnt;
    logic [CNT_WIDTH-1:0]   r_pend_cnt;
    // Bit k holds the pulse for stage k; the two bits past the chain model
    // the last PE's two-cycle latency and feed out_valid.
    logic [CHAIN_LEN+1:1]   r_sr;

    logic                   w_accept;
    logic                   w_last_accept;
    logic                   w_last_result;
    logic                   w_abort;

`ifdef MAC_CHAIN_CTRL_ABORT_EN
    assign w_abort = abort && ((r_state == S_RUN) || (r_state == S_DRAIN));
`else
    assign w_abort = 1'b0;
`endif

    assign in_ready      = (r_state == S_RUN) && (r_acc_cnt < r_len);
    assign w_accept      = in_valid && in_ready;
    assign w_last_accept = w_accept && (r_acc_cnt == r_len - CNT_WIDTH'(1));
    assign out_valid     = r_sr[CHAIN_LEN+1];
    // No beats are accepted in DRAIN, so a single outstanding result is the last.
    assign w_last_result = out_valid && (r_pend_cnt == CNT_WIDTH'(1));
    assign busy          = r_busy;
    assign done          = r_done;

    generate
        if (CHAIN_LEN == 1) begin : g_pe_single
            assign pe_pulse = w_accept;
        end else begin : g_pe_multi
            assign pe_pulse = {r_sr[CHAIN_LEN-1:1], w_accept};
        end
    endgenerate

    always_ff @(posedge DSP_clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_len      <= '0;
            r_acc_cnt  <= '0;
            r_pend_cnt <= '0;
            r_sr       <= '0;
        end else if (w_abort) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_acc_cnt  <= '0;
            r_pend_cnt <= '0;
            r_sr       <= '0;
        end else begin
            r_sr   <= {r_sr[CHAIN_LEN:1], w_accept};
            r_done <= 1'b0;

            if (w_accept && !out_valid) begin
                if (r_pend_cnt != '1) begin
                    r_pend_cnt <= r_pend_cnt + CNT_WIDTH'(1);
                end
            end else if (!w_accept && out_valid && (r_pend_cnt != '0)) begin
                r_pend_cnt <= r_pend_cnt - CNT_WIDTH'(1);
            end

            if (w_accept) begin
                r_acc_cnt <= r_acc_cnt + CNT_WIDTH'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len     <= cfg_len;
                        r_acc_cnt <= '0;
                        r_busy    <= 1'b1;
                        if (cfg_len == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_last_accept) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_last_result) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_chain_ctrl
// Description : Drives CHAIN_LEN=9 and CHAIN_LEN=3 controllers with the same
//               stimulus and checks each against an accept-history model.
//               Abort scenario included when MAC_CHAIN_CTRL_ABORT_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_chain_ctrl;
    localparam int W  = 16;
    localparam int L0 = 9;
    localparam int L1 = 3;

    logic          DSP_clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  cfg_len;
    logic          in_valid;
`ifdef MAC_CHAIN_CTRL_ABORT_EN
    logic          abort;
`endif
    logic          busy0, ir0, ov0, dn0;
    logic [L0-1:0] pp0;
    logic          busy1, ir1, ov1, dn1;
    logic [L1-1:0] pp1;

    always #5 DSP_clk = ~DSP_clk;

    mac_chain_ctrl #(.CHAIN_LEN(L0), .CNT_WIDTH(W)) dut9 (
        .DSP_clk(DSP_clk), .rst(rst), .start(start), .cfg_len(cfg_len),
        .busy(busy0), .in_valid(in_valid), .in_ready(ir0), .pe_pulse(pp0),
        .out_valid(ov0), .done(dn0)
`ifdef MAC_CHAIN_CTRL_ABORT_EN
        , .abort(abort)
`endif
    );

    mac_chain_ctrl #(.CHAIN_LEN(L1), .CNT_WIDTH(W)) dut3 (
        .DSP_clk(DSP_clk), .rst(rst), .start(start), .cfg_len(cfg_len),
        .busy(busy1), .in_valid(in_valid), .in_ready(ir1), .pe_pulse(pp1),
        .out_valid(ov1), .done(dn1)
`ifdef MAC_CHAIN_CTRL_ABORT_EN
        , .abort(abort)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: phase 0..3 = IDLE/RUN/DRAIN/DONE, plus the cycle
    // numbers of every accepted beat; pulses/results are derived from those.
    int L[2] = '{L0, L1};
    int phase[2], mlen[2], nacc[2], flush[2];
    int ovcnt[2], dncnt[2], done_cyc[2];
    bit hist[2][0:8191];

    task automatic chk(input string tag, input int i, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s dut%0d cyc=%0d: got %0h expected %0h", tag, i, cyc, o, e);
        end
    endtask

    function automatic bit past(input int i, input int s);
        return (s >= 0) && (s >= flush[i]) && hist[i][s];
    endfunction

    task automatic model_cycle(input int i);
        int          t;
        logic        eir, a, eov, more;
        logic [31:0] epe, ope;
        logic        obusy, oir, oov, odn;
        t = cyc;
        if (rst) begin
            phase[i] = 0;
            nacc[i]  = 0;
            flush[i] = t + 1;
        end
        eir = (phase[i] == 1) && (nacc[i] < mlen[i]);
        a   = in_valid && eir;
        hist[i][t] = a;
        epe    = '0;
        epe[0] = a;
        for (int k = 1; k < L[i]; k++) epe[k] = past(i, t - k);
        eov = past(i, t - L[i] - 1);

        obusy = (i == 0) ? busy0 : busy1;
        oir   = (i == 0) ? ir0   : ir1;
        oov   = (i == 0) ? ov0   : ov1;
        odn   = (i == 0) ? dn0   : dn1;
        ope   = (i == 0) ? 32'(pp0) : 32'(pp1);
        chk("busy",      i, 32'(obusy), 32'(phase[i] != 0));
        chk("in_ready",  i, 32'(oir),   32'(eir));
        chk("pe_pulse",  i, ope,        epe);
        chk("out_valid", i, 32'(oov),   32'(eov));
        chk("done",      i, 32'(odn),   32'(phase[i] == 3));
        if (oov) ovcnt[i]++;
        if (odn) begin
            dncnt[i]++;
            done_cyc[i] = t;
        end

        if (!rst) begin
`ifdef MAC_CHAIN_CTRL_ABORT_EN
            if (abort && (phase[i] == 1 || phase[i] == 2)) begin
                phase[i] = 0;
                nacc[i]  = 0;
                flush[i] = t + 1;
            end else
`endif
            case (phase[i])
                0: if (start) begin
                    mlen[i]  = int'(cfg_len);
                    nacc[i]  = 0;
                    phase[i] = (cfg_len == '0) ? 3 : 1;
                end
                1: if (a) begin
                    nacc[i]++;
                    if (nacc[i] == mlen[i]) phase[i] = 2;
                end
                2: if (eov) begin
                    more = 1'b0;
                    for (int s = t - L[i]; s < t; s++) if (past(i, s)) more = 1'b1;
                    if (!more) phase[i] = 3;
                end
                default: phase[i] = 0;
            endcase
        end
    endtask

    task automatic step();
        @(negedge DSP_clk);
        for (int i = 0; i < 2; i++) model_cycle(i);
        cyc++;
        @(posedge DSP_clk);
        #1;
    endtask

    initial begin
        int sc, ovb0, ovb1, dnb0, dnb1;
        for (int i = 0; i < 2; i++) begin
            phase[i] = 0; mlen[i] = 0; nacc[i] = 0; flush[i] = 0;
            ovcnt[i] = 0; dncnt[i] = 0; done_cyc[i] = -1;
        end
        rst = 1'b1; start = 1'b0; cfg_len = '0; in_valid = 1'b0;
`ifdef MAC_CHAIN_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        #2;
        chk("reset_outs", 0, {busy0, ir0, ov0, dn0, 23'd0, pp0}, 32'd0);
        chk("reset_outs", 1, {busy1, ir1, ov1, dn1, 25'd0, pp1}, 32'd0);
        step(); step();
        rst = 1'b0;
        step();

        // Nine-stage timing reference: 4 beats, in_valid high from cycle 1
        ovb0 = ovcnt[0];
        sc = cyc; start = 1'b1; cfg_len = 16'd4;
        step();
        start = 1'b0; cfg_len = 16'hBEEF; in_valid = 1'b1;
        repeat (20) step();
        in_valid = 1'b0;
        chk("r030_done_cycle", 0, 32'(done_cyc[0] - sc), 32'd15);
        chk("r030_results",    0, 32'(ovcnt[0] - ovb0),  32'd4);

        // Bubbles: valid toggling 1,0,1,0,1
        ovb0 = ovcnt[0]; ovb1 = ovcnt[1];
        start = 1'b1; cfg_len = 16'd3;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = (k % 2 == 0);
            step();
        end
        in_valid = 1'b0;
        repeat (15) step();
        chk("r031_results", 1, 32'(ovcnt[1] - ovb1), 32'd3);
        chk("r031_results", 0, 32'(ovcnt[0] - ovb0), 32'd3);

        // Zero-length job
        ovb0 = ovcnt[0]; dnb0 = dncnt[0];
        sc = cyc; start = 1'b1; cfg_len = 16'd0;
        step();
        start = 1'b0;
        repeat (3) step();
        chk("r032_done_cycle", 0, 32'(done_cyc[0] - sc), 32'd1);
        chk("r032_done_count", 0, 32'(dncnt[0] - dnb0),  32'd1);
        chk("r032_results",    0, 32'(ovcnt[0] - ovb0),  32'd0);

        // Start re-pulsed mid-job must be ignored
        ovb0 = ovcnt[0]; ovb1 = ovcnt[1];
        start = 1'b1; cfg_len = 16'd2;
        step();
        start = 1'b0; in_valid = 1'b1;
        step();
        start = 1'b1; cfg_len = 16'd7;
        step();
        start = 1'b0;
        repeat (20) step();
        in_valid = 1'b0;
        chk("r033_results", 0, 32'(ovcnt[0] - ovb0), 32'd2);
        chk("r033_results", 1, 32'(ovcnt[1] - ovb1), 32'd2);

        // Reset two cycles after the first accept
        start = 1'b1; cfg_len = 16'd5;
        step();
        start = 1'b0; in_valid = 1'b1;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("r034_async_clear", 0, {busy0, ir0, ov0, dn0, 23'd0, pp0}, 32'd0);
        chk("r034_async_clear", 1, {busy1, ir1, ov1, dn1, 25'd0, pp1}, 32'd0);
        in_valid = 1'b0;
        step(); step();
        rst = 1'b0;
        ovb0 = ovcnt[0]; ovb1 = ovcnt[1]; dnb0 = dncnt[0]; dnb1 = dncnt[1];
        repeat (20) step();
        chk("r034_stale_results", 0, 32'(ovcnt[0] - ovb0), 32'd0);
        chk("r034_stale_results", 1, 32'(ovcnt[1] - ovb1), 32'd0);
        chk("r034_stale_done",    0, 32'(dncnt[0] - dnb0), 32'd0);
        chk("r034_stale_done",    1, 32'(dncnt[1] - dnb1), 32'd0);

        // Randomized jobs with stray start pulses and cfg_len changes
        repeat (8) begin
            start = 1'b1; cfg_len = 16'($urandom_range(0, 6));
            step();
            repeat (30) begin
                in_valid = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) begin
                    start = 1'b1; cfg_len = 16'($urandom_range(0, 9));
                end else begin
                    start = 1'b0; cfg_len = 16'($urandom_range(0, 65535));
                end
                step();
            end
        end
        start = 1'b0; in_valid = 1'b0;
        repeat (25) step();

`ifdef MAC_CHAIN_CTRL_ABORT_EN
        // Abort while both controllers are draining
        dnb0 = dncnt[0]; dnb1 = dncnt[1];
        start = 1'b1; cfg_len = 16'd2;
        step();
        start = 1'b0; in_valid = 1'b1;
        step(); step();
        in_valid = 1'b0;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("r035_busy",     0, 32'(busy0), 32'd0);
        chk("r035_pe_pulse", 0, 32'(pp0),   32'd0);
        repeat (20) step();
        chk("r035_no_done", 0, 32'(dncnt[0] - dnb0), 32'd0);
        chk("r035_no_done", 1, 32'(dncnt[1] - dnb1), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mac_chain_ctrl.md
MAC_CHAIN_CTRL -- requirements
Module: mac_chain_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 9: number of cascaded MAC PEs driven; legal range 1..32.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the job length and beat counters.
REQ-003 SHALL have port DSP_clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1: single-cycle job request.
REQ-006 SHALL have port cfg_len, input, CNT_WIDTH: number of feature beats in the job; sampled when start is accepted.
REQ-007 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-008 SHALL have port in_valid, input, 1: feature/weight beat available from the feeder.
REQ-009 SHALL have port in_ready, output, 1: controller accepts the beat.
REQ-010 SHALL have port pe_pulse, output, CHAIN_LEN: bit k drives the pulse input of chain stage k.
REQ-011 SHALL have port out_valid, output, 1: last-stage cascade output holds a new result.
REQ-012 SHALL have port done, output, 1: one-cycle end-of-job strobe.

Function
REQ-013 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-014 IDLE->RUN SHALL occur when start=1 with cfg_len!=0; IDLE->DONE SHALL occur when start=1 with cfg_len=0; start outside IDLE SHALL be ignored.
REQ-015 in_ready SHALL be combinational, high only in RUN while accepted beats < cfg_len.
REQ-016 A beat SHALL be accepted in a cycle where in_valid=1 and in_ready=1.
REQ-017 pe_pulse[0] SHALL equal the accept condition combinationally, so data and pulse align in cycle c.
REQ-018 pe_pulse[k], for k>=1, SHALL be pe_pulse[k-1] registered one cycle, giving stage k its pulse in cycle c+k.
REQ-019 in_valid=0 in RUN SHALL insert a bubble: no pulse is issued, the skew pipeline keeps shifting, and no earlier beat is lost or duplicated.
REQ-020 out_valid SHALL be high in cycle c+CHAIN_LEN+1 for each beat accepted in cycle c (MAC_PE two-cycle latency plus skew), exactly once per beat.
REQ-021 RUN->DRAIN SHALL occur on the cycle after the cfg_len-th accept.
REQ-022 DRAIN->DONE SHALL occur in the cycle after the final out_valid.
REQ-023 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-024 The outstanding-result counter SHALL increment on accept, decrement on out_valid, and handle both in the same cycle with a net of 0; it SHALL never wrap.
REQ-025 cfg_len SHALL be captured in an internal register at start; later cfg_len changes SHALL have no effect on the running job.

Reset
REQ-026 On rst, the state SHALL go to IDLE, the counters and pulse shift register SHALL clear, and busy, in_ready, pe_pulse, out_valid and done SHALL all be 0, all asynchronously.
REQ-027 rst asserted mid-job SHALL discard all in-flight pulses; after release, no stale out_valid or done SHALL appear.

Configuration
REQ-028 When the macro MAC_CHAIN_CTRL_ABORT_EN is defined, the block SHALL have an input port abort, 1 bit; abort=1 in RUN or DRAIN SHALL clear the pulse shift register and counters and go to IDLE next cycle, with done suppressed.
REQ-029 When MAC_CHAIN_CTRL_ABORT_EN is undefined, the abort port and its logic SHALL be absent and behaviour SHALL be as in REQ-013..025.

Verification
REQ-030 The bench SHALL cover: CHAIN_LEN=9, cfg_len=4, in_valid held high from cycle 1 -> pe_pulse[0] high in cycles 1-4, pe_pulse[8] high in cycles 9-12, out_valid high in cycles 11-14, done in cycle 15.
REQ-031 The bench SHALL cover: CHAIN_LEN=3, cfg_len=3, in_valid toggling 1,0,1,0,1 -> out_valid exactly three times, each 4 cycles after its accept.
REQ-032 The bench SHALL cover: start with cfg_len=0 -> done high the next cycle, no pe_pulse and no out_valid.
REQ-033 The bench SHALL cover: start re-pulsed during RUN with cfg_len=7 -> ignored; the job completes with the original length.
REQ-034 The bench SHALL cover: rst asserted 2 cycles after the first accept -> all outputs 0 immediately, then no out_valid within 20 cycles after release.
REQ-035 The bench SHALL cover, with MAC_CHAIN_CTRL_ABORT_EN defined: abort in DRAIN -> pe_pulse 0 the next cycle, busy 0, done never asserted.
